// File: rtl/bitwise_pkg.sv
// Shared operation encoding for the bitwise unit.
package bitwise_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND   = 3'd0;
    localparam logic [OP_W-1:0] OP_OR    = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
    localparam logic [OP_W-1:0] OP_NOTA  = 3'd3;
    localparam logic [OP_W-1:0] OP_NAND  = 3'd4;
    localparam logic [OP_W-1:0] OP_NOR   = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASSB = 3'd7;

endpackage

// File: rtl/bitwise_core.sv
// Combinational bitwise function selector: (a, b, op) -> y.
module bitwise_core
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOTA:  y = ~a;
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_XNOR:  y = ~(a ^ b);
            OP_PASSB: y = b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_unit_pipe.sv
// Registered bitwise unit with valid/ready handshakes, burst accumulator and
// a count of results taken by the consumer.
module bitwise_unit_pipe
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic [WIDTH-1:0] acc_value
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_y_q, out_y_d;
    logic             out_zero_q, out_zero_d;
    logic             out_parity_q, out_parity_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;

    // Only out_ready reaches in_ready combinationally; the output slot is
    // free when empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign op_a     = in_acc ? acc_q : in_a;

    bitwise_core #(.WIDTH(WIDTH)) u_core (
        .a  (op_a),
        .b  (in_b),
        .op (in_op),
        .y  (result)
    );

    always_comb begin
        out_valid_d  = out_valid_q;
        out_y_d      = out_y_q;
        out_zero_d   = out_zero_q;
        out_parity_d = out_parity_q;
        acc_d        = acc_q;
        count_d      = count_q;

        if (out_valid_q && out_ready) begin
            count_d     = count_q + CNT_W'(1);
            out_valid_d = 1'b0;
        end

        if (accept) begin
            out_valid_d  = 1'b1;
            out_y_d      = result;
            out_zero_d   = (result == '0);
            out_parity_d = ^result;
            // last beat still emits its result but leaves the accumulator clean
            acc_d        = in_last ? '0 : result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_y_q      <= '0;
            out_zero_q   <= 1'b0;
            out_parity_q <= 1'b0;
            count_q      <= '0;
            acc_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_y_q      <= out_y_d;
            out_zero_q   <= out_zero_d;
            out_parity_q <= out_parity_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_y      = out_y_q;
    assign out_zero   = out_zero_q;
    assign out_parity = out_parity_q;
    assign out_count  = count_q;
    assign acc_value  = acc_q;

endmodule

// File: tb/tb_bitwise_unit_pipe.sv
// Directed bench for bitwise_unit_pipe; a second instance with a 2-bit
// counter shares the stimulus to exercise counter wrap.
module tb_bitwise_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_acc, in_last, out_ready;
    logic [7:0] in_a, in_b;
    logic [2:0] in_op;

    logic        in_ready, out_valid, out_zero, out_parity;
    logic [7:0]  out_y, acc_value;
    logic [15:0] out_count;

    logic        in_ready2, out_valid2, out_zero2, out_parity2;
    logic [7:0]  out_y2, acc_value2;
    logic [1:0]  out_count2;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    logic [7:0] exp_ops [8] = '{8'h05, 8'hAF, 8'hAA, 8'h5A, 8'hFA, 8'h50, 8'h55, 8'h0F};

    always #5 clk = ~clk;

    bitwise_unit_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
        .out_parity(out_parity), .out_count(out_count), .acc_value(acc_value)
    );

    bitwise_unit_pipe #(.WIDTH(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_y(out_y2), .out_zero(out_zero2),
        .out_parity(out_parity2), .out_count(out_count2), .acc_value(acc_value2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic acc, input logic last);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_acc   = acc;
        in_last  = last;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] exp_y);
        chk({tag, ".valid"},  out_valid, 1'b1);
        chk({tag, ".y"},      out_y, exp_y);
        chk({tag, ".zero"},   out_zero, exp_y == 8'h00);
        chk({tag, ".parity"}, out_parity, ^exp_y);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_op = '0; in_acc = 1'b0; in_last = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst.valid", out_valid, 1'b0);
        chk("rst.y", out_y, 8'h00);
        chk("rst.count", out_count, 16'd0);
        chk("rst.acc", acc_value, 8'h00);
        chk("rst.in_ready", in_ready, 1'b1);

        // Zero flag and 2-bit counter wrap: 5 drained results.
        drive(3'd2, 8'h5A, 8'h5A, 1'b0, 1'b0);
        tick();
        chk_out("xor_zero", 8'h00);
        for (int i = 1; i < 5; i++) begin
            drive(3'd7, 8'h00, 8'(i), 1'b0, 1'b0);
            tick();
            chk_out("wrap_beat", 8'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("wrap.valid", out_valid, 1'b0);
        chk("wrap.y_hold", out_y, 8'h04);
        chk("wrap.count16", out_count, 16'd5);
        chk("wrap.count2", out_count2, 2'd1);

        // Reset while a result is held under backpressure.
        out_ready = 1'b0;
        drive(3'd1, 8'h12, 8'h34, 1'b0, 1'b0);
        tick();
        chk("mid.valid_before", out_valid, 1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid.valid", out_valid, 1'b0);
        chk("mid.y", out_y, 8'h00);
        chk("mid.zero", out_zero, 1'b0);
        chk("mid.parity", out_parity, 1'b0);
        chk("mid.count", out_count, 16'd0);
        chk("mid.acc", acc_value, 8'h00);
        chk("mid.in_ready", in_ready, 1'b1);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        exp_cnt = 0;

        // All eight ops with A=A5, B=0F, back to back; last beat clears acc.
        for (int op = 0; op < 8; op++) begin
            drive(3'(op), 8'hA5, 8'h0F, 1'b0, op == 7);
            tick();
            chk_out("op", exp_ops[op]);
        end
        drive(3'd1, 8'h01, 8'h00, 1'b0, 1'b1);
        tick();
        chk_out("or_odd_parity", 8'h01);
        in_valid = 1'b0;
        tick();
        exp_cnt += 9;
        chk("ops.valid", out_valid, 1'b0);
        chk("ops.count", out_count, 16'(exp_cnt));
        chk("ops.acc", acc_value, 8'h00);

        // Backpressure: first result held three cycles, second beat waits.
        out_ready = 1'b0;
        drive(3'd0, 8'hFF, 8'h3C, 1'b0, 1'b0);
        tick();
        chk_out("bp.first", 8'h3C);
        drive(3'd1, 8'h00, 8'h81, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("bp.in_ready", in_ready, 1'b0);
            tick();
            chk_out("bp.hold", 8'h3C);
        end
        chk("bp.acc_held", acc_value, 8'h3C);
        out_ready = 1'b1;
        #1;
        chk("bp.in_ready_rel", in_ready, 1'b1);
        tick();
        chk_out("bp.second", 8'h81);
        in_valid = 1'b0;
        tick();
        exp_cnt += 2;
        chk("bp.valid", out_valid, 1'b0);
        chk("bp.count", out_count, 16'(exp_cnt));
        chk("bp.acc", acc_value, 8'h00);

        // Accumulator burst: load F0, XOR FF, AND 3C with last.
        drive(3'd7, 8'h00, 8'hF0, 1'b0, 1'b0);
        tick();
        chk_out("acc.load", 8'hF0);
        chk("acc.after_load", acc_value, 8'hF0);
        drive(3'd2, 8'hAA, 8'hFF, 1'b1, 1'b0);
        tick();
        chk_out("acc.xor", 8'h0F);
        chk("acc.after_xor", acc_value, 8'h0F);
        drive(3'd0, 8'hAA, 8'h3C, 1'b1, 1'b1);
        tick();
        chk_out("acc.and_last", 8'h0C);
        chk("acc.after_last", acc_value, 8'h00);
        in_valid = 1'b0;
        tick();
        exp_cnt += 3;
        chk("acc.count", out_count, 16'(exp_cnt));

        // Full throughput: ten beats in ten cycles.
        for (int i = 0; i < 10; i++) begin
            drive(3'd3, 8'(i), 8'h00, 1'b0, 1'b0);
            tick();
            chk_out("tp.beat", ~8'(i));
        end
        in_valid = 1'b0;
        tick();
        exp_cnt += 10;
        chk("tp.valid", out_valid, 1'b0);
        chk("tp.count", out_count, 16'(exp_cnt));
        chk("tp.count2", out_count2, 2'(exp_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
